// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath (shared memory port, single ALU,
// IR/PC/A/B/ALUOut/Data holding registers). Decodes Op/funct3/funct7b5 into
// per-cycle datapath enables and mux selects for lw, sw, R-type, I-type ALU,
// beq and jal, handshakes with memory via mem_ready, and flags illegal opcodes
// and memory wait timeouts.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   Op, funct3, funct7b5 instruction fields from the IR
//   Zero                ALU zero flag (used in BEQ)
//   mem_ready           memory completes the current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ALUControl, ImmSrc, RegWrite
//                       datapath control pins
//   illegal_op          one-cycle pulse in DECODE on an unsupported opcode
//   mem_timeout         sticky flag: memory stalled WAIT_LIMIT cycles
//   state               current FSM state, for debug
module multicycle_controller #(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpBeq  = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StAluWb    = 4'd7,
    StExecuteI = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10
  } stateE;

  stateE stateQ, stateD;

  logic [CNT_W-1:0] waitCntQ, waitCntD;
  logic             timeoutQ, timeoutD;
  logic             waiting;

  // Raw (pre-reset-gating) control signals
  logic       pcUpdate;
  logic       branch;
  logic       irWriteRaw;
  logic       memWriteRaw;
  logic       regWriteRaw;
  logic       illegalRaw;
  logic [1:0] aluOp;

  // State register and wait-counter/timeout registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= StFetch;
      waitCntQ <= '0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
      timeoutQ <= timeoutD;
    end
  end

  // Next state and Moore outputs
  always_comb begin
    stateD      = StFetch;
    pcUpdate    = 1'b0;
    branch      = 1'b0;
    irWriteRaw  = 1'b0;
    memWriteRaw = 1'b0;
    regWriteRaw = 1'b0;
    illegalRaw  = 1'b0;
    aluOp       = 2'b00;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;

    case (stateQ)
      StFetch: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        irWriteRaw = mem_ready;
        pcUpdate   = mem_ready;
        stateD     = mem_ready ? StDecode : StFetch;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Op)
          OpLw, OpSw: stateD = StMemAdr;
          OpR:        stateD = StExecuteR;
          OpI:        stateD = StExecuteI;
          OpJal:      stateD = StJal;
          OpBeq:      stateD = StBeq;
          default: begin
            stateD     = StFetch;
            illegalRaw = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        stateD  = (Op == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        stateD = mem_ready ? StMemWb : StMemRead;
      end
      StMemWb: begin
        ResultSrc   = 2'b01;
        regWriteRaw = 1'b1;
        stateD      = StFetch;
      end
      StMemWrite: begin
        AdrSrc      = 1'b1;
        memWriteRaw = 1'b1;
        stateD      = mem_ready ? StFetch : StMemWrite;
      end
      StExecuteR: begin
        ALUSrcA = 2'b10;
        aluOp   = 2'b10;
        stateD  = StAluWb;
      end
      StExecuteI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluOp   = 2'b10;
        stateD  = StAluWb;
      end
      StAluWb: begin
        regWriteRaw = 1'b1;
        stateD      = StFetch;
      end
      StBeq: begin
        ALUSrcA = 2'b10;
        aluOp   = 2'b01;
        branch  = 1'b1;
        stateD  = StFetch;
      end
      StJal: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcUpdate = 1'b1;
        stateD   = StAluWb;
      end
      default: stateD = StFetch;
    endcase
  end

  // Write enables are forced low combinationally while reset is held, so a
  // mid-access reset cannot leak a store or register write.
  assign PCWrite    = rst_n & (pcUpdate | (branch & Zero));
  assign IRWrite    = rst_n & irWriteRaw;
  assign MemWrite   = rst_n & memWriteRaw;
  assign RegWrite   = rst_n & regWriteRaw;
  assign illegal_op = rst_n & illegalRaw;

  // Immediate format select
  always_comb begin
    case (Op)
      OpLw, OpI: ImmSrc = 2'b00;
      OpSw:      ImmSrc = 2'b01;
      OpBeq:     ImmSrc = 2'b10;
      OpJal:     ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  // ALU decoder; subtract only for R-type (Op[5]=1) with funct7b5 set
  always_comb begin
    ALUControl = 3'b000;
    case (aluOp)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (Op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Memory wait counter: counts consecutive stalled cycles in the states that
  // own the memory port; timeout sets on the edge where the count reaches
  // WAIT_LIMIT and then sticks until reset.
  assign waiting = ((stateQ == StFetch) || (stateQ == StMemRead) || (stateQ == StMemWrite)) &&
                   !mem_ready;

  always_comb begin
    waitCntD = '0;
    if (waiting) begin
      waitCntD = (waitCntQ == {CNT_W{1'b1}}) ? waitCntQ : waitCntQ + 1'b1;
    end
    timeoutD = timeoutQ;
    if ((WAIT_LIMIT != 0) && waiting && (waitCntD == CNT_W'(WAIT_LIMIT))) begin
      timeoutD = 1'b1;
    end
  end

  assign mem_timeout = timeoutQ;
  assign state       = stateQ;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. A driver issues one cycle of inputs
// at a time and pushes the hand-written expected outputs for that cycle into a
// scoreboard queue; a monitor pops and compares on the falling edge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op, mem_timeout;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_controller #(
    .WAIT_LIMIT(16),
    .CNT_W     (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Op         (Op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .illegal_op (illegal_op),
    .mem_timeout(mem_timeout),
    .state      (state)
  );

  // Packed vector: {state,PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,
  //                 ALUControl,ImmSrc,RegWrite,illegal_op,mem_timeout}
  logic [21:0] expQ[$];
  int          tagQ[$];
  int          nCmp = 0;
  int          nErr = 0;
  int          cycN = 0;

  // Current instruction fields and hand-chosen expectations
  logic [6:0] pOp = 7'd0;
  logic [2:0] pF3 = 3'd0;
  logic       pF7 = 1'b0;
  logic [1:0] expImm = 2'b00;
  logic [2:0] expAlu = 3'b000;
  logic       expTo  = 1'b0;

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [1:0] imm, input logic [2:0] alu);
    pOp    = op;
    pF3    = f3;
    pF7    = f7;
    expImm = imm;
    expAlu = alu;
  endtask

  // One clock cycle: apply inputs, then queue the expected outputs. The Moore
  // values per state are copied from the state table; write enables and the
  // illegal flag are given explicitly by the caller.
  task automatic cyc(input logic [3:0] st, input logic rst, input logic mr, input logic z,
                     input logic pcw, input logic irw, input logic mw, input logic ill);
    logic       adr, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] alu;
    @(posedge clk);
    #1;
    rst_n     = rst;
    mem_ready = mr;
    Zero      = z;
    Op        = pOp;
    funct3    = pF3;
    funct7b5  = pF7;
    adr = 1'b0; rw = 1'b0; rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
    case (st)
      4'd0:  begin rs = 2'b10; sb = 2'b10; end
      4'd1:  begin sa = 2'b01; sb = 2'b01; end
      4'd2:  begin sa = 2'b10; sb = 2'b01; end
      4'd3:  adr = 1'b1;
      4'd4:  begin rs = 2'b01; rw = 1'b1; end
      4'd5:  adr = 1'b1;
      4'd6:  begin sa = 2'b10; alu = expAlu; end
      4'd7:  rw = 1'b1;
      4'd8:  begin sa = 2'b10; sb = 2'b01; alu = expAlu; end
      4'd9:  begin sa = 2'b01; sb = 2'b10; end
      4'd10: begin sa = 2'b10; alu = 3'b001; end
      default: ;
    endcase
    expQ.push_back({st, pcw, adr, mw, irw, rs, sa, sb, alu, expImm, rw, ill, expTo});
    tagQ.push_back(cycN);
    cycN++;
  endtask

  // Monitor: compare every queued expectation against the DUT on the falling edge
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      logic [21:0] e, a;
      int          t;
      e = expQ.pop_front();
      t = tagQ.pop_front();
      a = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, illegal_op, mem_timeout};
      nCmp++;
      if (a !== e) begin
        nErr++;
        $display("FAIL cycle%0d: got st=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b alu=%b imm=%b rw=%b ill=%b to=%b, want st=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b alu=%b imm=%b rw=%b ill=%b to=%b",
                 t, a[21:18], a[17], a[16], a[15], a[14], a[13:12], a[11:10], a[9:8],
                 a[7:5], a[4:3], a[2], a[1], a[0], e[21:18], e[17], e[16], e[15], e[14],
                 e[13:12], e[11:10], e[9:8], e[7:5], e[4:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; Zero = 1'b0;
    Op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;

    // Reset held, then released with memory stalled: no IRWrite until ready
    instr(7'b0000011, 3'b010, 1'b0, 2'b00, 3'b000);
    cyc(0, 0, 1, 0, 0, 0, 0, 0);  // enables gated even with mem_ready=1
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);

    // lw, memory always ready: 0,1,2,3,4
    cyc(0, 1, 1, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    cyc(2, 1, 1, 0, 0, 0, 0, 0);
    cyc(3, 1, 1, 0, 0, 0, 0, 0);
    cyc(4, 1, 1, 0, 0, 0, 0, 0);

    // sw with three stalled MEMWRITE cycles: MemWrite high four cycles
    instr(7'b0100011, 3'b010, 1'b0, 2'b01, 3'b000);
    cyc(0, 1, 1, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    cyc(2, 1, 1, 0, 0, 0, 0, 0);
    cyc(5, 1, 0, 0, 0, 0, 1, 0);
    cyc(5, 1, 0, 0, 0, 0, 1, 0);
    cyc(5, 1, 0, 0, 0, 0, 1, 0);
    cyc(5, 1, 1, 0, 0, 0, 1, 0);

    // sw interrupted by reset mid-MEMWRITE
    cyc(0, 1, 1, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    cyc(2, 1, 1, 0, 0, 0, 0, 0);
    cyc(5, 1, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);

    // R-type sub
    instr(7'b0110011, 3'b000, 1'b1, 2'b00, 3'b001);
    cyc(0, 1, 1, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    cyc(6, 1, 1, 0, 0, 0, 0, 0);
    cyc(7, 1, 1, 0, 0, 0, 0, 0);

    // R-type and
    instr(7'b0110011, 3'b111, 1'b0, 2'b00, 3'b010);
    cyc(0, 1, 1, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    cyc(6, 1, 1, 0, 0, 0, 0, 0);
    cyc(7, 1, 1, 0, 0, 0, 0, 0);

    // R-type or
    instr(7'b0110011, 3'b110, 1'b0, 2'b00, 3'b011);
    cyc(0, 1, 1, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    cyc(6, 1, 1, 0, 0, 0, 0, 0);
    cyc(7, 1, 1, 0, 0, 0, 0, 0);

    // addi with funct7b5=1 must still add
    instr(7'b0010011, 3'b000, 1'b1, 2'b00, 3'b000);
    cyc(0, 1, 1, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    cyc(8, 1, 1, 0, 0, 0, 0, 0);
    cyc(7, 1, 1, 0, 0, 0, 0, 0);

    // slti
    instr(7'b0010011, 3'b010, 1'b0, 2'b00, 3'b101);
    cyc(0, 1, 1, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    cyc(8, 1, 1, 0, 0, 0, 0, 0);
    cyc(7, 1, 1, 0, 0, 0, 0, 0);

    // beq taken, then not taken
    instr(7'b1100011, 3'b000, 1'b0, 2'b10, 3'b000);
    cyc(0, 1, 1, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    cyc(10, 1, 1, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 0, 0, 0, 0);
    cyc(10, 1, 1, 0, 0, 0, 0, 0);

    // jal
    instr(7'b1101111, 3'b000, 1'b0, 2'b11, 3'b000);
    cyc(0, 1, 1, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    cyc(9, 1, 1, 0, 1, 0, 0, 0);
    cyc(7, 1, 1, 0, 0, 0, 0, 0);

    // Illegal opcode, then 16 stalled FETCH cycles trip the timeout
    instr(7'h7F, 3'b000, 1'b0, 2'b00, 3'b000);
    cyc(0, 1, 1, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 16; k++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    expTo = 1'b1;
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 1);
    cyc(0, 1, 1, 0, 1, 1, 0, 0);

    // Drain the scoreboard within a bounded number of cycles
    for (int w = 0; w < 10 && expQ.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    if (expQ.size() > 0) begin
      nErr++;
      $display("FAIL drain: got %0d pending, want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
